wall_query_arbiter: RTL

//  Shares the single maze-wall lookup port between NUM_REQ game-logic requesters (pacman, ghosts).

---
 rtl/wall_query_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/wall_query_arbiter.sv
// wall_query_arbiter
//   Shares the single maze-wall lookup port between NUM_REQ game-logic requesters.
//   Queries are granted round-robin and issued only while the renderer is not
//   using the port (bright=0). One query is in flight at a time.
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   bright           1 = active video, lookup port owned by the renderer
//   req/req_x/req_y  per-requester level request and packed coordinates
//   ack, wall_hit    one-hot result pulse and the hit bit that goes with it
//   lk_sel           1 = arbiter owns the lookup port
//   lk_valid, lk_x/y lookup strobe and coordinates
//   lk_hit           lookup result, valid LK_LAT cycles after lk_valid
//   busy             high whenever a query is being serviced
module wall_query_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned COORD_W = 10,
  parameter int unsigned LK_LAT  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bright,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*COORD_W-1:0] req_x,
  input  logic [NUM_REQ*COORD_W-1:0] req_y,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       wall_hit,
  output logic                       lk_sel,
  output logic                       lk_valid,
  output logic [COORD_W-1:0]         lk_x,
  output logic [COORD_W-1:0]         lk_y,
  input  logic                       lk_hit,
  output logic                       busy
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(LK_LAT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     gnt_q, gnt_d;
  logic [COORD_W-1:0]  lk_x_q, lk_x_d;
  logic [COORD_W-1:0]  lk_y_q, lk_y_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                hit_q, hit_d;

  logic                found;
  logic [IdxW-1:0]     win;
  logic [IdxW-1:0]     cand;

  // Round-robin search: first asserted request starting at rr_ptr_q.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr_q;
    cand  = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IdxW'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    lk_x_d   = lk_x_q;
    lk_y_d   = lk_y_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    unique case (state_q)
      StIdle: begin
        if (!bright && found) begin
          gnt_d   = win;
          lk_x_d  = req_x[win*COORD_W +: COORD_W];
          lk_y_d  = req_y[win*COORD_W +: COORD_W];
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Strobe is withheld while the renderer owns the port; coords stay latched.
        if (!bright) begin
          cnt_d   = CntW'(LK_LAT);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == CntW'(1)) begin
          hit_d   = lk_hit;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        rr_ptr_d = (gnt_q == IdxW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      lk_x_q   <= '0;
      lk_y_q   <= '0;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      lk_x_q   <= lk_x_d;
      lk_y_q   <= lk_y_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == StDone) ack[gnt_q] = 1'b1;
    wall_hit = (state_q == StDone) && hit_q;
    lk_valid = (state_q == StIssue) && !bright;
    lk_sel   = !bright;
    lk_x     = lk_x_q;
    lk_y     = lk_y_q;
    busy     = (state_q != StIdle);
  end

endmodule
